// File: rtl/screen_update_seq_if.sv
// ----------------------------------------------------------------------------
// screen_update_seq_if
// Bundles the hash-snapshot input side and the screen-RAM write side of
// screen_update_seq.
//
// Handshake: hash_valid is a one-cycle valid pulse with no ready. hashin and
// hashout are sampled on the clock edge where hash_valid=1. The sequencer
// always accepts. A snapshot that arrives while an update runs waits in a
// one-deep pending buffer. A newer pending snapshot replaces an older one,
// and drop_cnt counts each replacement.
// wr_en is a plain write strobe with no back-pressure. wr_x/wr_y/wr_data are
// meaningful only while wr_en=1.
//
// Signals
//   hash_valid, hashin, hashout, vblank   producer -> sequencer
//   busy, wr_en, wr_x, wr_y, wr_data,
//   done, drop_cnt                        sequencer -> consumer
//   dbg_state                             sequencer FSM state (debug)
// Modports: master = producer/consumer side, slave = sequencer.
// ----------------------------------------------------------------------------
interface screen_update_seq_if #(
   parameter int IN_BITS  = 1024,
   parameter int OUT_BITS = 256
);
   logic                hash_valid;
   logic [IN_BITS-1:0]  hashin;
   logic [OUT_BITS-1:0] hashout;
   logic                vblank;
   logic                busy;
   logic                wr_en;
   logic [6:0]          wr_x;
   logic [4:0]          wr_y;
   logic [7:0]          wr_data;
   logic                done;
   logic [7:0]          drop_cnt;
   logic [2:0]          dbg_state;

   modport master (
      output hash_valid, hashin, hashout, vblank,
      input  busy, wr_en, wr_x, wr_y, wr_data, done, drop_cnt, dbg_state
   );

   modport slave (
      input  hash_valid, hashin, hashout, vblank,
      output busy, wr_en, wr_x, wr_y, wr_data, done, drop_cnt, dbg_state
   );
endinterface

// File: rtl/screen_update_seq.sv
// ----------------------------------------------------------------------------
// screen_update_seq
// Copies a snapshot of the miner's input block and digest into the text
// screen RAM as hex-nibble character codes. It issues one cell per cycle and
// writes only while vblank=1, so the renderer never shows a half-updated
// frame.
//   rows 0..3 : IN_BITS/4 nibbles of hashin, MS nibble first, 64 per row
//   OUT_ROW   : OUT_BITS/4 nibbles of hashout, MS nibble first
//
// Ports
//   clk   system clock
//   rst   asynchronous reset, active-high
//   bus   screen_update_seq_if.slave
//         (hash_valid/hashin/hashout/vblank in;
//          busy/wr_en/wr_x/wr_y/wr_data/done/drop_cnt/dbg_state out)
//
// Optional feature: define SCREEN_CLEAR_ON_RESET_EN to add a CLEAR state.
// After reset, CLEAR fills all 128x32 cells with BLANK_CODE, row-major with
// x fastest, and only during vblank.
// ----------------------------------------------------------------------------
module screen_update_seq #(
   parameter int         IN_BITS    = 1024,
   parameter int         OUT_BITS   = 256,
   parameter logic [4:0] OUT_ROW    = 5'd5,
   parameter logic [7:0] BLANK_CODE = 8'h16
) (
   input  logic               clk,
   input  logic               rst,
   screen_update_seq_if.slave bus
);

`ifdef SCREEN_CLEAR_ON_RESET_EN
   typedef enum logic [2:0] {S_IDLE, S_WAIT_BLANK, S_WR_IN, S_WR_OUT, S_CLEAR} state_t;
   localparam state_t RESET_STATE = S_CLEAR;
`else
   typedef enum logic [2:0] {S_IDLE, S_WAIT_BLANK, S_WR_IN, S_WR_OUT} state_t;
   localparam state_t RESET_STATE = S_IDLE;
`endif

   localparam logic [11:0] IN_LAST = 12'(IN_BITS / 4 - 1);
   localparam logic [11:0] OUT_END = 12'(OUT_BITS / 4);

   state_t              state_q, state_d;
   logic [11:0]         cnt_q, cnt_d;
   logic [IN_BITS-1:0]  act_in_q, act_in_d, pend_in_q, pend_in_d;
   logic [OUT_BITS-1:0] act_out_q, act_out_d, pend_out_q, pend_out_d;
   logic                pend_v_q, pend_v_d;
   logic [7:0]          drop_q, drop_d;
   logic                wr_en_q, wr_en_d;
   logic [6:0]          wr_x_q, wr_x_d;
   logic [4:0]          wr_y_q, wr_y_d;
   logic [7:0]          wr_data_q, wr_data_d;
   logic                done_q, done_d;
   logic                complete;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RESET_STATE;
         cnt_q      <= '0;
         act_in_q   <= '0;
         act_out_q  <= '0;
         pend_in_q  <= '0;
         pend_out_q <= '0;
         pend_v_q   <= 1'b0;
         drop_q     <= '0;
         wr_en_q    <= 1'b0;
         wr_x_q     <= '0;
         wr_y_q     <= '0;
         wr_data_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         act_in_q   <= act_in_d;
         act_out_q  <= act_out_d;
         pend_in_q  <= pend_in_d;
         pend_out_q <= pend_out_d;
         pend_v_q   <= pend_v_d;
         drop_q     <= drop_d;
         wr_en_q    <= wr_en_d;
         wr_x_q     <= wr_x_d;
         wr_y_q     <= wr_y_d;
         wr_data_q  <= wr_data_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      act_in_d   = act_in_q;
      act_out_d  = act_out_q;
      pend_in_d  = pend_in_q;
      pend_out_d = pend_out_q;
      pend_v_d   = pend_v_q;
      drop_d     = drop_q;
      wr_en_d    = 1'b0;
      wr_x_d     = wr_x_q;
      wr_y_d     = wr_y_q;
      wr_data_d  = wr_data_q;
      done_d     = 1'b0;
      complete   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.hash_valid) begin
               act_in_d  = bus.hashin;
               act_out_d = bus.hashout;
               cnt_d     = '0;
               state_d   = S_WAIT_BLANK;
            end
         end
         S_WAIT_BLANK: begin
            if (bus.vblank) state_d = S_WR_IN;
         end
         S_WR_IN: begin
            // The active snapshot shifts left one nibble per write, so the
            // next cell is always the top nibble.
            if (bus.vblank) begin
               wr_en_d   = 1'b1;
               wr_x_d    = {1'b0, cnt_q[5:0]};
               wr_y_d    = cnt_q[10:6];
               wr_data_d = {4'h0, act_in_q[IN_BITS-1 -: 4]};
               act_in_d  = act_in_q << 4;
               if (cnt_q == IN_LAST) begin
                  cnt_d   = '0;
                  state_d = S_WR_OUT;
               end else begin
                  cnt_d = cnt_q + 12'd1;
               end
            end
         end
         S_WR_OUT: begin
            // Once the count reaches OUT_END, the last write is already on the
            // bus. This cycle finishes the update and pulses done.
            if (cnt_q == OUT_END) begin
               complete = 1'b1;
               done_d   = 1'b1;
            end else if (bus.vblank) begin
               wr_en_d   = 1'b1;
               wr_x_d    = {1'b0, cnt_q[5:0]};
               wr_y_d    = OUT_ROW;
               wr_data_d = {4'h0, act_out_q[OUT_BITS-1 -: 4]};
               act_out_d = act_out_q << 4;
               cnt_d     = cnt_q + 12'd1;
            end
         end
`ifdef SCREEN_CLEAR_ON_RESET_EN
         S_CLEAR: begin
            if (bus.vblank) begin
               wr_en_d   = 1'b1;
               wr_x_d    = cnt_q[6:0];
               wr_y_d    = cnt_q[11:7];
               wr_data_d = BLANK_CODE;
               cnt_d     = cnt_q + 12'd1;
               if (cnt_q == 12'hFFF) complete = 1'b1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // Completion goes straight to the next update when one is waiting.
      // A snapshot that arrives on this same edge is kept, so none is lost.
      if (complete) begin
         cnt_d = '0;
         if (pend_v_q) begin
            act_in_d  = pend_in_q;
            act_out_d = pend_out_q;
            state_d   = S_WAIT_BLANK;
            pend_v_d  = bus.hash_valid;
            if (bus.hash_valid) begin
               pend_in_d  = bus.hashin;
               pend_out_d = bus.hashout;
            end
         end else if (bus.hash_valid) begin
            act_in_d  = bus.hashin;
            act_out_d = bus.hashout;
            state_d   = S_WAIT_BLANK;
         end else begin
            state_d = S_IDLE;
         end
      end else if (bus.hash_valid && (state_q != S_IDLE)) begin
         pend_in_d  = bus.hashin;
         pend_out_d = bus.hashout;
         pend_v_d   = 1'b1;
         if (pend_v_q && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
      end
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_x      = wr_x_q;
   assign bus.wr_y      = wr_y_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.done      = done_q;
   assign bus.drop_cnt  = drop_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_screen_update_seq.sv
// ----------------------------------------------------------------------------
// tb_screen_update_seq
// Directed sequence with random hash data. The reference model expands each
// accepted snapshot into its list of (x, y, char) screen writes, in display
// order, and queues them in exp_q. A monitor pops exp_q on every observed
// write.
// ----------------------------------------------------------------------------
module tb_screen_update_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   screen_update_seq_if #(.IN_BITS(1024), .OUT_BITS(256)) bus ();

   screen_update_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks   = 0;
   int failures = 0;

   int cyc          = 0;
   logic vb_prev    = 1'b0;
   int wr_cnt       = 0;
   int done_cnt     = 0;
   int done_cyc     = -1;
   int first_wr_cyc = -1;
   int last_wr_cyc  = -1;
   logic busy_at_done = 1'b0;
   logic [19:0] exp_q[$];
   logic [19:0] mon_exp;
   logic        mon_have;
   logic [7:0]  scr [32][128];

`ifdef SCREEN_CLEAR_ON_RESET_EN
   localparam logic CLR_BUSY = 1'b1;
`else
   localparam logic CLR_BUSY = 1'b0;
`endif

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Edge counter and the vblank value each edge sampled
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      vb_prev <= bus.vblank;
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) begin
         wr_cnt++;
         if (first_wr_cyc < 0) first_wr_cyc = cyc;
         last_wr_cyc = cyc;
         scr[bus.wr_y][bus.wr_x] = bus.wr_data;
         chk("wr_during_vblank", 64'(vb_prev), 64'd1);
         mon_have = (exp_q.size() != 0);
         chk("wr_extra", 64'(mon_have), 64'd1);
         if (mon_have) begin
            mon_exp = exp_q.pop_front();
            chk("wr_cell", 64'({bus.wr_x, bus.wr_y, bus.wr_data}), 64'(mon_exp));
         end
      end
      if (bus.done === 1'b1) begin
         done_cnt++;
         done_cyc     = cyc;
         busy_at_done = bus.busy;
      end
   end

   // Reference model: expected write list for one update
   task automatic push_update(input logic [1023:0] hin, input logic [255:0] hout);
      logic [1023:0] t;
      logic [255:0]  u;
      for (int n = 0; n < 256; n++) begin
         t = hin >> (4 * (255 - n));
         exp_q.push_back({7'(n % 64), 5'(n / 64), 4'h0, t[3:0]});
      end
      for (int n = 0; n < 64; n++) begin
         u = hout >> (4 * (63 - n));
         exp_q.push_back({7'(n), 5'd5, 4'h0, u[3:0]});
      end
   endtask

   task automatic push_clear();
      for (int c = 0; c < 4096; c++) exp_q.push_back({7'(c % 128), 5'(c / 128), 8'h16});
   endtask

   function automatic logic [1023:0] rand_in();
      logic [1023:0] v = '0;
      for (int i = 0; i < 32; i++) v = {v[991:0], 32'($urandom())};
      return v;
   endfunction

   function automatic logic [255:0] rand_out();
      logic [255:0] v = '0;
      for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom())};
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle hash_valid pulse; n is the edge that samples it
   task automatic send(input logic [1023:0] hin, input logic [255:0] hout, output int n);
      bus.hashin     = hin;
      bus.hashout    = hout;
      bus.hash_valid = 1'b1;
      tick();
      bus.hash_valid = 1'b0;
      n = cyc;
   endtask

   task automatic wait_done(input int target, input int limit);
      int k = 0;
      while (done_cnt < target && k < limit) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("done_timeout", 64'(done_cnt >= target), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_wr_en"},    64'(bus.wr_en),    64'd0);
      chk({tag, "_done"},     64'(bus.done),     64'd0);
      chk({tag, "_busy"},     64'(bus.busy),     64'(CLR_BUSY));
      chk({tag, "_drop"},     64'(bus.drop_cnt), 64'd0);
      chk({tag, "_wr_xydat"}, 64'({bus.wr_x, bus.wr_y, bus.wr_data}), 64'd0);
   endtask

   task automatic after_reset_release();
`ifdef SCREEN_CLEAR_ON_RESET_EN
      int k = 0;
      int d0 = done_cnt;
      wr_cnt = 0;
      push_clear();
      tick();
      while (bus.busy === 1'b1 && k < 6000) begin
         tick();
         k++;
      end
      repeat (2) tick();
      chk("clear_writes", 64'(wr_cnt), 64'd4096);
      chk("clear_busy_end", 64'(bus.busy), 64'd0);
      chk("clear_no_done", 64'(done_cnt), 64'(d0));
`else
      tick();
`endif
   endtask

   // Global time bound
   initial begin
      #5ms;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1023:0] hin, xa, xb;
      logic [255:0]  hout, ya, yb, yc;
      int n, d0, k;

      for (int y = 0; y < 32; y++)
         for (int x = 0; x < 128; x++) scr[y][x] = 8'hAA;

      bus.hash_valid = 1'b0;
      bus.hashin     = '0;
      bus.hashout    = '0;
      bus.vblank     = 1'b1;

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      after_reset_release();

      // Ramp pattern: latency, count and spot cells
      hin  = '0;
      hout = '0;
      for (int i = 0; i < 256; i++) hin = {hin[1019:0], 4'(i % 16)};
      for (int i = 0; i < 64; i++) hout = {hout[251:0], 4'(15 - (i % 16))};
      wr_cnt = 0;
      first_wr_cyc = -1;
      push_update(hin, hout);
      d0 = done_cnt;
      send(hin, hout, n);
      tick();
      chk("ramp_busy_mid", 64'(bus.busy), 64'd1);
      wait_done(d0 + 1, 1000);
      chk("ramp_first_wr", 64'(first_wr_cyc), 64'(n + 2));
      chk("ramp_last_wr", 64'(last_wr_cyc), 64'(n + 321));
      chk("ramp_done_cyc", 64'(done_cyc), 64'(n + 322));
      chk("ramp_writes", 64'(wr_cnt), 64'd320);
      chk("ramp_busy_at_done", 64'(busy_at_done), 64'd0);
      chk("ramp_cell_0_0", 64'(scr[0][0]), 64'h00);
      chk("ramp_cell_63_3", 64'(scr[3][63]), 64'h0F);
      chk("ramp_cell_0_5", 64'(scr[5][0]), 64'h0F);
      chk("ramp_cell_63_5", 64'(scr[5][63]), 64'h00);

      // vblank toggling every 50 cycles during an update
      tick();
      hin  = rand_in();
      hout = rand_out();
      wr_cnt = 0;
      push_update(hin, hout);
      d0 = done_cnt;
      send(hin, hout, n);
      k = 1;
      while (done_cnt < d0 + 1 && k < 3000) begin
         if ((k % 50) == 0) bus.vblank = ~bus.vblank;
         tick();
         k++;
      end
      bus.vblank = 1'b1;
      chk("toggle_done", 64'(done_cnt), 64'(d0 + 1));
      chk("toggle_writes", 64'(wr_cnt), 64'd320);
      chk("toggle_q_empty", 64'(exp_q.size()), 64'd0);

      // Three snapshots while busy: latest wins, two drops
      repeat (3) tick();
      hin  = rand_in();
      hout = rand_out();
      xa = rand_in();
      xb = rand_in();
      ya = rand_out();
      yb = rand_out();
      yc = rand_out();
      wr_cnt = 0;
      push_update(hin, hout);
      d0 = done_cnt;
      send(hin, hout, n);
      repeat (10) tick();
      send(xa, ya, n);
      repeat (10) tick();
      send(xb, yb, n);
      repeat (10) tick();
      hin = rand_in();
      push_update(hin, yc);
      send(hin, yc, n);
      tick();
      chk("pend_drop_cnt", 64'(bus.drop_cnt), 64'd2);
      wait_done(d0 + 2, 2000);
      repeat (400) tick();
      chk("pend_done_count", 64'(done_cnt), 64'(d0 + 2));
      chk("pend_writes", 64'(wr_cnt), 64'd640);
      chk("pend_idle_busy", 64'(bus.busy), 64'd0);
      chk("pend_shows_c", 64'(scr[5][0]), 64'({4'h0, yc[255:252]}));

      // Snapshot on the same edge as done: back-to-back update
      hin  = rand_in();
      hout = rand_out();
      push_update(hin, hout);
      d0 = done_cnt;
      send(hin, hout, n);
      k = 0;
      while (cyc < n + 321 && k < 500) begin
         tick();
         k++;
      end
      hin  = rand_in();
      hout = rand_out();
      push_update(hin, hout);
      bus.hashin     = hin;
      bus.hashout    = hout;
      bus.hash_valid = 1'b1;
      tick();
      bus.hash_valid = 1'b0;
      chk("b2b_done_now", 64'(bus.done), 64'd1);
      chk("b2b_busy_held", 64'(bus.busy), 64'd1);
      wait_done(d0 + 2, 1000);
      chk("b2b_second_done_cyc", 64'(done_cyc), 64'(n + 644));
      chk("b2b_drop_unchanged", 64'(bus.drop_cnt), 64'd2);

      // Reset at write 100, then restart from cell 0
      tick();
      hin  = rand_in();
      hout = rand_out();
      wr_cnt = 0;
      push_update(hin, hout);
      send(hin, hout, n);
      k = 0;
      while (wr_cnt < 100 && k < 500) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("rst_reached_100", 64'(wr_cnt), 64'd100);
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_async");
      exp_q.delete();
      repeat (2) tick();
      rst = 1'b0;
      after_reset_release();
      hin  = rand_in();
      hout = rand_out();
      wr_cnt = 0;
      push_update(hin, hout);
      d0 = done_cnt;
      send(hin, hout, n);
      wait_done(d0 + 1, 1000);
      chk("restart_writes", 64'(wr_cnt), 64'd320);
      chk("restart_drop", 64'(bus.drop_cnt), 64'd0);

      repeat (5) tick();
      chk("final_q_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
